snake_dir_encoder: RTL and testbench

Input-side front end for the seven-segment snake game: conditions the raw push-buttons and produces the movement command stream the game core consumes. It synchronises and debounces the three buttons and decodes them into a 2-bit direction code. It generates the periodic move strobe and enforces the no-reversal rule, halting the stream on a violation. The game core samples `dir` only when `step` is high.

---
 rtl/snake_dir_encoder_pkg.sv | 37 +++
 rtl/snake_dir_encoder_if.sv | 16 +
 rtl/snake_dir_encoder_btn_debounce.sv | 42 ++++
 rtl/snake_dir_encoder.sv | 85 ++++++++
 tb/tb_snake_dir_encoder.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/snake_dir_encoder_pkg.sv
// snake_pkg: shared types and helpers for the snake input front end.
//   dir_t          : direction codes (UP/RIGHT/DOWN/LEFT)
//   state_t        : command-stream FSM states
//   BTN_IDLE       : button level whose decode equals the reset direction
//   is_reverse     : true when two directions are opposite
//   decode_buttons : debounced buttons -> requested direction
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [2:0] BTN_IDLE = 3'b101;

  // Opposite pairs differ only in the MSB: 00<->10, 01<->11.
  function automatic logic is_reverse(dir_t a, dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

  function automatic dir_t decode_buttons(logic [2:0] btn);
    dir_t d;
    d = DIR_UP;
    if (!btn[2])                 d = DIR_DOWN;
    else if (btn[1:0] == 2'b01)  d = DIR_LEFT;
    else if (btn[1:0] == 2'b10)  d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/snake_dir_encoder_if.sv
// snake_dir_encoder_if: button/command bundle between the board side and
// the encoder.
//   button : raw button levels (async)      clr  : sync restart pulse
//   dir    : committed direction            step : one-cycle move strobe
//   err    : sticky reversal error          btn_db : debounced buttons
interface snake_dir_encoder_if;
  logic [2:0] button;
  logic       clr;
  logic [1:0] dir;
  logic       step;
  logic       err;
  logic [2:0] btn_db;

  modport master (output button, clr, input dir, step, err, btn_db);
  modport slave  (input button, clr, output dir, step, err, btn_db);
endinterface

// File: rtl/snake_dir_encoder_btn_debounce.sv
// btn_debounce: one-bit 2-flop synchroniser followed by a debounce counter.
//   clk, rst : clock, async active-low reset
//   i_btn    : raw asynchronous button level
//   o_db     : debounced level (registered)
// A new level is accepted only after DEBOUNCE_CYCLES consecutive
// synchronised samples that differ from the current stable value.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter bit RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_db
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          r_s1, r_s2, r_stable;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1     <= RST_VAL;
      r_s2     <= RST_VAL;
      r_stable <= RST_VAL;
      r_cnt    <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (r_s2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_s2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_db = r_stable;
endmodule

// File: rtl/snake_dir_encoder.sv
// snake_dir_encoder: debounces three buttons, decodes a direction request
// and emits a periodic move strobe with the no-reversal rule enforced.
//   clk, rst : clock, async active-low reset
//   bus      : slave side of snake_dir_encoder_if
//              (button, clr in; dir, step, err, btn_db out)
module snake_dir_encoder
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int STEP_PERIOD     = 33554432,
  parameter bit REV_IS_ERR      = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  snake_dir_encoder_if.slave   bus
);
  localparam int SW = $clog2(STEP_PERIOD);

  logic [2:0]    w_btn_raw, w_btn_db;
  dir_t          w_req;
  logic          w_tick;

  state_t        r_state;
  dir_t          r_dir;
  logic          r_step, r_err;
  logic [SW-1:0] r_cnt;

  assign w_btn_raw = bus.button;

  for (genvar g = 0; g < 3; g++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RST_VAL         (BTN_IDLE[g])
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .i_btn (w_btn_raw[g]),
      .o_db  (w_btn_db[g])
    );
  end

  assign w_req  = decode_buttons(w_btn_db);
  assign w_tick = (r_cnt == SW'(STEP_PERIOD - 1));

  // clr takes priority over a coincident tick, so it is checked first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_dir   <= DIR_LEFT;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (bus.clr) begin
      r_state <= ST_RUN;
      r_dir   <= DIR_LEFT;
      r_step  <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        ST_RUN: begin
          r_cnt <= w_tick ? '0 : r_cnt + SW'(1);
          if (w_tick) begin
            if (!is_reverse(w_req, r_dir)) begin
              r_dir  <= w_req;
              r_step <= 1'b1;
            end else if (REV_IS_ERR) begin
              r_err   <= 1'b1;
              r_state <= ST_HALT;
            end else begin
              r_step <= 1'b1;   // reversal ignored: direction held
            end
          end
        end
        default: ;              // HALT: counter and direction frozen
      endcase
    end
  end

  assign bus.dir    = r_dir;
  assign bus.step   = r_step;
  assign bus.err    = r_err;
  assign bus.btn_db = w_btn_db;
endmodule

// File: tb/tb_snake_dir_encoder.sv
module tb_snake_dir_encoder;
  logic clk, rst;
  int   checks = 0;
  int   errors = 0;

  snake_dir_encoder_if if0();
  snake_dir_encoder_if if1();

  snake_dir_encoder #(.DEBOUNCE_CYCLES(4), .STEP_PERIOD(8), .REV_IS_ERR(1'b1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  snake_dir_encoder #(.DEBOUNCE_CYCLES(4), .STEP_PERIOD(8), .REV_IS_ERR(1'b0))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges from now until dut0 step is seen (1-based); -1 on timeout.
  task automatic wait_step(output int n);
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      if (if0.step) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; if0.button = 3'b101; if0.clr = 1'b0;
    if1.button = 3'b101; if1.clr = 1'b0;
    #1 rst = 1'b0;
    #2;
    checks++; if (if0.dir !== 2'b11) begin errors++; $display("FAIL reset_dir: got %b exp 11", if0.dir); end
    checks++; if (if0.step !== 1'b0) begin errors++; $display("FAIL reset_step: got %b exp 0", if0.step); end
    checks++; if (if0.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", if0.err); end
    checks++; if (if0.btn_db !== 3'b101) begin errors++; $display("FAIL reset_btn_db: got %b exp 101", if0.btn_db); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    wait_step(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL reset_first_step: got %0d exp 8", n); end
    wait_step(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL reset_period: got %0d exp 8", n); end
    checks++; if (if0.dir !== 2'b11) begin errors++; $display("FAIL reset_idle_dir: got %b exp 11", if0.dir); end
  endtask

  task automatic test_turn();
    int n;
    if0.button = 3'b011;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin
        checks++; if (if0.btn_db !== 3'b101) begin errors++; $display("FAIL turn_db_early: got %b exp 101", if0.btn_db); end
      end
      if (i == 6) begin
        checks++; if (if0.btn_db !== 3'b011) begin errors++; $display("FAIL turn_db_edge6: got %b exp 011", if0.btn_db); end
      end
    end
    wait_step(n);
    checks++; if (n !== 2) begin errors++; $display("FAIL turn_step_time: got %0d exp 2", n); end
    checks++; if (if0.dir !== 2'b10) begin errors++; $display("FAIL turn_dir: got %b exp 10", if0.dir); end
    if0.button = 3'b101;
    wait_step(n);
    checks++; if (if0.dir !== 2'b11) begin errors++; $display("FAIL turn_back_dir: got %b exp 11", if0.dir); end
  endtask

  task automatic test_bounce();
    int  nstep = 0;
    logic db_ok = 1'b1, dir_ok = 1'b1;
    if0.button = 3'b111;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 1) if0.button = 3'b101;
      if (i == 2) if0.button = 3'b111;
      if (i == 3) if0.button = 3'b101;
      if (if0.btn_db !== 3'b101) db_ok = 1'b0;
      if (if0.step) begin nstep++; if (if0.dir !== 2'b11) dir_ok = 1'b0; end
    end
    checks++; if (!db_ok) begin errors++; $display("FAIL bounce_db: got changed exp 101 held"); end
    checks++; if (nstep !== 2) begin errors++; $display("FAIL bounce_steps: got %0d exp 2", nstep); end
    checks++; if (!dir_ok) begin errors++; $display("FAIL bounce_dir: got changed exp 11 held"); end
  endtask

  task automatic test_reversal();
    int   n;
    logic quiet = 1'b1, sticky = 1'b1;
    if0.button = 3'b110;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (if0.step) quiet = 1'b0;
      if (i == 7) begin
        checks++; if (if0.err !== 1'b0) begin errors++; $display("FAIL rev_err_early: got %b exp 0", if0.err); end
      end
    end
    checks++; if (if0.err !== 1'b1) begin errors++; $display("FAIL rev_err: got %b exp 1", if0.err); end
    checks++; if (if0.dir !== 2'b11) begin errors++; $display("FAIL rev_dir: got %b exp 11", if0.dir); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (if0.step) quiet = 1'b0;
      if (if0.err !== 1'b1) sticky = 1'b0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL rev_halt_step: got step exp none"); end
    checks++; if (!sticky) begin errors++; $display("FAIL rev_err_sticky: got dropped exp 1"); end
    if0.button = 3'b101;
    repeat (10) @(posedge clk);
    #1 if0.clr = 1'b1;
    @(posedge clk); #1 if0.clr = 1'b0;
    checks++; if (if0.err !== 1'b0) begin errors++; $display("FAIL clr_err: got %b exp 0", if0.err); end
    checks++; if (if0.dir !== 2'b11) begin errors++; $display("FAIL clr_dir: got %b exp 11", if0.dir); end
    wait_step(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL clr_first_step: got %0d exp 8", n); end
  endtask

  task automatic test_clr_tick();
    int n;
    if0.button = 3'b011;
    repeat (7) @(posedge clk);
    #1 if0.clr = 1'b1;
    @(posedge clk); #1 if0.clr = 1'b0;
    checks++; if (if0.step !== 1'b0) begin errors++; $display("FAIL clr_tick_step: got %b exp 0", if0.step); end
    checks++; if (if0.dir !== 2'b11) begin errors++; $display("FAIL clr_tick_dir: got %b exp 11", if0.dir); end
    wait_step(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL clr_tick_next: got %0d exp 8", n); end
    checks++; if (if0.dir !== 2'b10) begin errors++; $display("FAIL clr_tick_commit: got %b exp 10", if0.dir); end
  endtask

  task automatic test_reset_mid();
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    checks++; if (if0.dir !== 2'b11) begin errors++; $display("FAIL rstmid_dir: got %b exp 11", if0.dir); end
    checks++; if (if0.btn_db !== 3'b101) begin errors++; $display("FAIL rstmid_db: got %b exp 101", if0.btn_db); end
    checks++; if (if0.step !== 1'b0) begin errors++; $display("FAIL rstmid_step: got %b exp 0", if0.step); end
    if0.button = 3'b101;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    wait_step(n);
    checks++; if (n !== 8) begin errors++; $display("FAIL rstmid_first_step: got %0d exp 8", n); end
    checks++; if (if0.dir !== 2'b11) begin errors++; $display("FAIL rstmid_step_dir: got %b exp 11", if0.dir); end
  endtask

  // dut1 shares reset with dut0, so it is aligned to the step just seen.
  task automatic test_rev_noerr();
    int   nstep = 0;
    logic err_ok = 1'b1, dir_ok = 1'b1;
    if1.button = 3'b110;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (if1.err !== 1'b0) err_ok = 1'b0;
      if (if1.step) begin nstep++; if (if1.dir !== 2'b11) dir_ok = 1'b0; end
    end
    checks++; if (nstep !== 3) begin errors++; $display("FAIL noerr_steps: got %0d exp 3", nstep); end
    checks++; if (!err_ok) begin errors++; $display("FAIL noerr_err: got 1 exp 0"); end
    checks++; if (!dir_ok) begin errors++; $display("FAIL noerr_dir: got changed exp 11"); end
  endtask

  initial begin
    test_reset();
    test_turn();
    test_bounce();
    test_reversal();
    test_clr_tick();
    test_reset_mid();
    test_rev_noerr();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
